// File: rtl/opsel_pkg.sv
// Shared definitions for the operand select stage: source index constants and the
// EMPTY/ONE/TWO occupancy encoding reusable by other valid/ready pipeline stages.
package opsel_pkg;

    localparam int SRC_REGFILE = 0;
    localparam int SRC_IMM     = 1;
    localparam int SRC_PC      = 2;
    localparam int SRC_FWD     = 3;

    typedef enum logic [1:0] {
        HS_EMPTY = 2'd0,
        HS_ONE   = 2'd1,
        HS_TWO   = 2'd2
    } hs_state_e;

    function automatic logic hs_has_data(hs_state_e s);
        return s != HS_EMPTY;
    endfunction

    function automatic logic hs_can_accept(hs_state_e s);
        return s != HS_TWO;
    endfunction

endpackage

// File: rtl/operand_index_mux.sv
// Combinational NUM_SOURCES:1 selector over a flattened bus; an index past the last
// source yields all-zero data and raises out_of_range.
module operand_index_mux
    import opsel_pkg::*;
#(
    parameter int  DATA_WIDTH  = 32,
    parameter int  NUM_SOURCES = 4,
    localparam int SEL_WIDTH   = $clog2(NUM_SOURCES)
) (
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] sources,
    input  logic [SEL_WIDTH-1:0]              sel,
    output logic [DATA_WIDTH-1:0]             data,
    output logic                              out_of_range
);

    // One extra bit so the limit is representable when NUM_SOURCES is a power of two.
    localparam logic [SEL_WIDTH:0] LIMIT = (SEL_WIDTH+1)'(NUM_SOURCES);

    always_comb begin
        data         = '0;
        out_of_range = ({1'b0, sel} >= LIMIT);
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if ({1'b0, sel} == (SEL_WIDTH+1)'(i)) begin
                data = sources[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/operand_select_stage.sv
// Registered ALU operand A/B selection with a 2-entry skid buffer on a valid/ready handshake.
// Optional macro OPSEL_STALL_COUNT_EN adds a 32-bit stallCount output.
module operand_select_stage
    import opsel_pkg::*;
#(
    parameter int  DATA_WIDTH  = 32,
    parameter int  NUM_SOURCES = 4,
    localparam int SEL_WIDTH   = $clog2(NUM_SOURCES)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] potentialOperands,
    input  logic [SEL_WIDTH-1:0]              selectOperandA,
    input  logic [SEL_WIDTH-1:0]              selectOperandB,
    input  logic                              inValid,
    output logic                              inReady,
    output logic [DATA_WIDTH-1:0]             chosenOperandA,
    output logic [DATA_WIDTH-1:0]             chosenOperandB,
    output logic                              outValid,
    input  logic                              outReady,
`ifdef OPSEL_STALL_COUNT_EN
    output logic [31:0]                       stallCount,
`endif
    output logic                              selectError
);

    logic [DATA_WIDTH-1:0] mux_a;
    logic [DATA_WIDTH-1:0] mux_b;
    logic                  oor_a;
    logic                  oor_b;
    logic                  accept;

    hs_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] m_a_q, m_a_d;
    logic [DATA_WIDTH-1:0] m_b_q, m_b_d;
    logic [DATA_WIDTH-1:0] s_a_q, s_a_d;
    logic [DATA_WIDTH-1:0] s_b_q, s_b_d;
    logic                  out_valid_q, out_valid_d;
    logic                  in_ready_q, in_ready_d;
    logic                  select_error_q, select_error_d;

    operand_index_mux #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_SOURCES (NUM_SOURCES)
    ) u_mux_a (
        .sources      (potentialOperands),
        .sel          (selectOperandA),
        .data         (mux_a),
        .out_of_range (oor_a)
    );

    operand_index_mux #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_SOURCES (NUM_SOURCES)
    ) u_mux_b (
        .sources      (potentialOperands),
        .sel          (selectOperandB),
        .data         (mux_b),
        .out_of_range (oor_b)
    );

    // Ready flop idles high; masking with reset keeps inReady low only while reset is held.
    assign inReady        = in_ready_q && !reset;
    assign accept         = inValid && inReady;
    assign outValid       = out_valid_q;
    assign chosenOperandA = m_a_q;
    assign chosenOperandB = m_b_q;
    assign selectError    = select_error_q;

    always_comb begin
        state_d        = state_q;
        m_a_d          = m_a_q;
        m_b_d          = m_b_q;
        s_a_d          = s_a_q;
        s_b_d          = s_b_q;
        select_error_d = select_error_q || (accept && (oor_a || oor_b));

        case (state_q)
            HS_EMPTY: begin
                if (accept) begin
                    m_a_d   = mux_a;
                    m_b_d   = mux_b;
                    state_d = HS_ONE;
                end
            end
            HS_ONE: begin
                if (accept && outReady) begin
                    m_a_d = mux_a;
                    m_b_d = mux_b;
                end else if (accept) begin
                    s_a_d   = mux_a;
                    s_b_d   = mux_b;
                    state_d = HS_TWO;
                end else if (outReady) begin
                    state_d = HS_EMPTY;
                end
            end
            HS_TWO: begin
                if (outReady) begin
                    m_a_d   = s_a_q;
                    m_b_d   = s_b_q;
                    state_d = HS_ONE;
                end
            end
            default: state_d = HS_EMPTY;
        endcase

        out_valid_d = hs_has_data(state_d);
        in_ready_d  = hs_can_accept(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= HS_EMPTY;
            m_a_q          <= '0;
            m_b_q          <= '0;
            s_a_q          <= '0;
            s_b_q          <= '0;
            out_valid_q    <= 1'b0;
            in_ready_q     <= 1'b1;
            select_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            m_a_q          <= m_a_d;
            m_b_q          <= m_b_d;
            s_a_q          <= s_a_d;
            s_b_q          <= s_b_d;
            out_valid_q    <= out_valid_d;
            in_ready_q     <= in_ready_d;
            select_error_q <= select_error_d;
        end
    end

`ifdef OPSEL_STALL_COUNT_EN
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q + 32'(out_valid_q && !outReady);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stallCount = stall_count_q;
`endif

endmodule
